// File: rtl/sigmoid_grad_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_grad_pipe
// Brief    : Sigmoid backward pass, dx = g * y * (1 - y), signed Q6.9 data,
//            two-stage pipeline with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_grad_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] y_in,
   input  logic [15:0] g_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] dx,
   output logic        out_clamp,
   output logic [15:0] xfer_cnt
);

   localparam logic [9:0]         c_one  = 10'h200;   // 1.0 in Q9
   localparam logic [16:0]        c_rnd1 = 17'd256;   // half LSB after >> 9
   localparam logic signed [24:0] c_rnd2 = 25'sd256;

   // pipeline state
   logic                v1_q, v1_d;
   logic                v2_q, v2_d;
   logic [7:0]          d_q, d_d;
   logic [15:0]         g_q, g_d;
   logic                clamp1_q, clamp1_d;
   logic [15:0]         dx_q, dx_d;
   logic                clamp2_q, clamp2_d;
   logic [15:0]         cnt_q, cnt_d;

   // combinational datapath
   logic                w_e1, w_e2;
   logic                w_y_neg, w_y_over;
   logic [9:0]          w_yc, w_om;
   logic [19:0]         w_prod1;
   logic [16:0]         w_sum1;
   logic [7:0]          w_d;
   logic signed [24:0]  w_prod2, w_sum2;
   logic [15:0]         w_dx;
   logic                w_unused;

   // Ready chain: a stage can load when empty or when the stage after it moves.
   assign w_e2     = ~v2_q | out_ready;
   assign w_e1     = ~v1_q | w_e2;
   assign in_ready = w_e1;

   // Stage-1 math: clamp y into [0, 1.0] and form d = round(y * (1 - y)).
   always_comb begin
      w_y_neg  = y_in[15];
      w_y_over = ~y_in[15] & (y_in[14:0] > 15'h0200);
      if (w_y_neg) begin
         w_yc = '0;
      end else if (w_y_over) begin
         w_yc = c_one;
      end else begin
         w_yc = y_in[9:0];
      end
      w_om    = c_one - w_yc;
      w_prod1 = {10'b0, w_yc} * {10'b0, w_om};
      // yc*om peaks at 0x10000, so bit 16 is the top live bit
      w_sum1  = w_prod1[16:0] + c_rnd1;
      w_d     = w_sum1[16:9];
   end

   // Stage-2 math: signed g times unsigned d, rounded half-up back to Q9.
   always_comb begin
      w_prod2 = $signed({{9{g_q[15]}}, g_q}) * $signed({17'b0, d_q});
      w_sum2  = w_prod2 + c_rnd2;
      w_dx    = w_sum2[24:9];
   end

   // Discarded fraction bits and the always-zero top of the stage-1 product.
   assign w_unused = ^{w_prod1[19:17], w_sum1[8:0], w_sum2[8:0]};

   // Next-state: stages load on their enable, bubbles collapse, count transfers.
   always_comb begin
      v1_d     = v1_q;
      d_d      = d_q;
      g_d      = g_q;
      clamp1_d = clamp1_q;
      v2_d     = v2_q;
      dx_d     = dx_q;
      clamp2_d = clamp2_q;
      cnt_d    = cnt_q;
      if (w_e1) begin
         v1_d = in_valid;
         if (in_valid) begin
            d_d      = w_d;
            g_d      = g_in;
            clamp1_d = w_y_neg | w_y_over;
         end
      end
      if (w_e2) begin
         v2_d = v1_q;
         if (v1_q) begin
            dx_d     = w_dx;
            clamp2_d = clamp1_q;
         end
      end
      if (v2_q & out_ready) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // State registers; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q     <= 1'b0;
         d_q      <= '0;
         g_q      <= '0;
         clamp1_q <= 1'b0;
         v2_q     <= 1'b0;
         dx_q     <= '0;
         clamp2_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         v1_q     <= v1_d;
         d_q      <= d_d;
         g_q      <= g_d;
         clamp1_q <= clamp1_d;
         v2_q     <= v2_d;
         dx_q     <= dx_d;
         clamp2_q <= clamp2_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = v2_q;
   assign dx        = dx_q;
   assign out_clamp = clamp2_q;
   assign xfer_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_grad_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_grad_pipe
// Brief    : Directed self-checking bench for sigmoid_grad_pipe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_grad_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] y_in;
   logic [15:0] g_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] dx;
   logic        out_clamp;
   logic [15:0] xfer_cnt;

   int          n_vec = 0;
   int          n_err = 0;
   int          ai, oi, occ, acc, nx, cyc;
   logic        stalled, seen;
   logic [15:0] held;

   always #5 clk = ~clk;

   sigmoid_grad_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y_in      (y_in),
      .g_in      (g_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dx        (dx),
      .out_clamp (out_clamp),
      .xfer_cnt  (xfer_cnt)
   );

   // advance one cycle and settle 1 time unit after the active edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 16'(out_valid), 16'h0001);
   endtask

   // one isolated pair through an empty pipe with out_ready high
   task automatic run_one(input string tag, input logic [15:0] y, input logic [15:0] g,
                          input logic [15:0] exp_dx, input logic exp_cl);
      out_ready = 1'b1;
      y_in      = y;
      g_in      = g;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      wait_valid(tag);
      chk({tag, "_dx"}, dx, exp_dx);
      chk({tag, "_clamp"}, 16'(out_clamp), 16'(exp_cl));
      tick();
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; y_in = '0; g_in = '0;
      #12;
      chk("rst_out_valid", 16'(out_valid), 16'h0000);
      chk("rst_dx", dx, 16'h0000);
      chk("rst_clamp", 16'(out_clamp), 16'h0000);
      chk("rst_xfer", xfer_cnt, 16'h0000);
      chk("rst_in_ready", 16'(in_ready), 16'h0001);
      rst = 1'b1;
      tick();

      // ---------------- nominal value and latency ----------------
      y_in = 16'h0100; g_in = 16'h0200; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk("nom_in_ready", 16'(in_ready), 16'h0001);
      tick();                                     // accepted at edge N
      in_valid = 1'b0;
      chk("nom_lat_early", 16'(out_valid), 16'h0000);
      tick();                                     // edge N+1
      chk("nom_lat", 16'(out_valid), 16'h0001);
      chk("nom_dx", dx, 16'h0080);
      chk("nom_clamp", 16'(out_clamp), 16'h0000);
      tick();
      chk("nom_drained", 16'(out_valid), 16'h0000);
      chk("nom_xfer", xfer_cnt, 16'h0001);

      // ---------------- directed values ----------------
      run_one("round",    16'h0080, 16'h0200, 16'h0060, 1'b0);
      run_one("clamp_hi", 16'h0300, 16'h0200, 16'h0000, 1'b1);
      run_one("clamp_lo", 16'hFF00, 16'h0200, 16'h0000, 1'b1);
      run_one("g_min",    16'h0100, 16'h8000, 16'hE000, 1'b0);
      run_one("y_zero",   16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      run_one("y_one",    16'h0200, 16'h7FFF, 16'h0000, 1'b0);
      run_one("g_neg",    16'h0100, 16'hFE00, 16'hFF80, 1'b0);
      chk("dir_xfer", xfer_cnt, 16'h0008);

      // ---------------- absorb from empty with out_ready low ----------------
      out_ready = 1'b0; in_valid = 1'b1; y_in = 16'h0100; acc = 0;
      for (int c = 0; c < 6; c++) begin
         g_in = 16'(16'h0200 * (acc + 1));
         #1;
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      chk("absorb_count", 16'(acc), 16'h0002);
      chk("absorb_ready", 16'(in_ready), 16'h0000);
      chk("absorb_dx0", dx, 16'h0080);
      out_ready = 1'b1;
      #1;
      chk("ready_follow", 16'(in_ready), 16'h0001);
      tick();
      chk("absorb_dx1", dx, 16'h0100);
      tick();
      chk("absorb_empty", 16'(out_valid), 16'h0000);
      chk("absorb_xfer", xfer_cnt, 16'h000A);

      // ---------------- 10-entry ramp, out_ready low cycles 3..7 ----------------
      pulse_reset();
      ai = 0; oi = 0; occ = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 40 && oi < 10; c++) begin
         out_ready = !(c >= 3 && c <= 7);
         in_valid  = (ai < 10);
         y_in      = 16'h0100;
         g_in      = 16'(16'h0200 * (ai + 1));
         #1;
         chk("bp_ready", 16'(in_ready), (occ == 2 && !out_ready) ? 16'h0000 : 16'h0001);
         if (stalled) begin
            chk("bp_hold_valid", 16'(out_valid), 16'h0001);
            chk("bp_hold_dx", dx, held);
         end
         stalled = out_valid && !out_ready;
         held    = dx;
         if (out_valid && out_ready) begin
            chk("bp_order", dx, 16'(16'h0080 * (oi + 1)));
            oi++;
            occ--;
         end
         if (in_valid && in_ready) begin
            ai++;
            occ++;
         end
         tick();
      end
      in_valid = 1'b0;
      chk("bp_results", 16'(oi), 16'h000A);
      chk("bp_xfer", xfer_cnt, 16'h000A);

      // ---------------- reset while full ----------------
      out_ready = 1'b0; in_valid = 1'b1; y_in = 16'h0100; g_in = 16'h0400;
      tick();
      tick();
      in_valid = 1'b0;
      chk("mid_full", 16'(out_valid), 16'h0001);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_out_valid", 16'(out_valid), 16'h0000);
      chk("mid_xfer", xfer_cnt, 16'h0000);
      chk("mid_in_ready", 16'(in_ready), 16'h0001);
      rst = 1'b1;
      in_valid = 1'b1; g_in = 16'h0C00; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid("mid_first");
      chk("mid_first_dx", dx, 16'h0300);
      chk("mid_first_xfer0", xfer_cnt, 16'h0000);
      tick();
      chk("mid_first_xfer1", xfer_cnt, 16'h0001);

      // ---------------- counter wrap ----------------
      pulse_reset();
      y_in = '0; g_in = '0; in_valid = 1'b1; out_ready = 1'b1;
      nx = 0; cyc = 0; seen = 1'b0;
      while (nx < 65537 && cyc < 70000) begin
         if (out_valid) nx++;
         tick();
         cyc++;
         if (nx == 65535 && !seen) begin
            chk("wrap_ffff", xfer_cnt, 16'hFFFF);
            seen = 1'b1;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("wrap_bound", 16'(cyc < 70000), 16'h0001);
      chk("wrap_cnt", xfer_cnt, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sigmoid_grad_pipe.md
# sigmoid_grad_pipe

Backward-pass companion to the forward sigmoid activation unit. It takes a forward sigmoid output y = σ(x) and an upstream gradient g, and returns the input gradient dx = g · y · (1 − y). All values use the same signed 16-bit fixed point as the forward path (9 fractional bits, 1.0 = 16'h0200). It is a 2-stage pipeline with valid/ready handshakes on both sides and sits between the activation cache and the layer's weight-gradient datapath.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  the (y_in, g_in) pair is valid.
- in_ready  out  1  the block accepts the pair this cycle.
- y_in  in  16  signed, forward sigmoid output.
- g_in  in  16  signed, upstream gradient.
- out_valid  out  1  dx is valid.
- out_ready  in  1  downstream accepts dx.
- dx  out  16  signed, input gradient.
- out_clamp  out  1  y_in for this result was outside [0, 1.0] and was clamped.
- xfer_cnt  out  16  count of completed output transfers; wraps.

## Operation
- Transfers:
  - Input transfer happens on a cycle with in_valid & in_ready.
  - Output transfer happens on a cycle with out_valid & out_ready.
- Stage 1 (registered on input transfer):
  - Clamp y: if y_in < 0, yc = 0. If y_in > 16'h0200, yc = 16'h0200. Otherwise yc = y_in.
  - clamp1 = 1 when a clamp occurred.
  - om = 16'h0200 − yc (unsigned, 10 bits).
  - d = (yc·om + 256) >> 9. This is an unsigned 8-bit value with maximum 16'h80 (0.25), rounded half-up.
  - Register d, g_in and clamp1; set v1.
- Stage 2:
  - prod = g · {1'b0, d}, a signed 25-bit result.
  - dx = (prod + 256) >>> 9, an arithmetic shift with half-up rounding.
  - |dx| ≤ |g|/4 + 1, so no saturation logic is required.
  - Register dx and out_clamp; set v2.
- Flow control:
  - e2 = ~v2 | out_ready.
  - e1 = ~v1 | e2.
  - in_ready = e1. This is combinational from out_ready; no register sits on the ready path.
  - Stage 2 loads when e2. Its valid becomes v1, so bubbles collapse.
  - Stage 1 loads when e1. Its valid becomes in_valid.
- Ordering and stability:
  - Results are delivered in strict input order.
  - While out_valid & ~out_ready, dx and out_clamp stay stable and out_valid stays high.
- xfer_cnt increments by 1 on each output transfer. It wraps 16'hFFFF → 16'h0000.

## Timing
- Reset: when rst is low, v1, v2, out_valid, dx, out_clamp and xfer_cnt all go to 0 asynchronously.
  - in_ready reads 1 while in reset.
  - A transfer in flight when reset asserts is dropped. No partial result is ever emitted.
- Latency:
  - An input transfer at edge N gives out_valid high after edge N+1, when out_ready was high at N+1.
  - That is 2 cycles from acceptance to a presentable result.
- Throughput: 1 result per cycle with out_ready held high.
- Backpressure:
  - With out_ready low, the pipe absorbs at most 2 pairs, then in_ready falls.
  - When out_ready rises, in_ready rises in the same cycle.
- Same-cycle input and output transfer while full: both happen, and occupancy is unchanged.
- Boundaries:
  - y_in = 0 or 16'h0200 gives d = 0 and dx = 0.
  - g_in = 16'h8000 (−64.0) must not overflow.

## Test plan
- Nominal value:
  - Stimulus: y_in = 16'h0100, g_in = 16'h0200, out_ready = 1.
  - Response: dx = 16'h0080 and out_clamp = 0, with out_valid exactly 2 cycles after acceptance.
- Rounding:
  - Stimulus: y_in = 16'h0080, g_in = 16'h0200.
  - Response: dx = 16'h0060.
- Clamp and extreme gradient:
  - Stimulus: y_in = 16'h0300 → response dx = 0, out_clamp = 1. Stimulus: y_in = 16'hFF00 → response dx = 0, out_clamp = 1.
  - Stimulus: y_in = 16'h0100, g_in = 16'h8000 → response dx = 16'hE000.
- Backpressure:
  - Stimulus: in_valid held with a 10-entry ramp, and out_ready low for cycles 3–7.
  - Response: exactly 2 pairs are accepted before in_ready drops. dx is stable while stalled. All 10 results arrive in order with no duplicate or drop.
  - Response: after 10 results, xfer_cnt = 10.
- Reset mid-stream:
  - Stimulus: assert rst between clock edges while the pipe is full.
  - Response: out_valid and xfer_cnt go to 0 immediately. The first output after release corresponds to the first pair accepted after release.
- Counter wrap:
  - Stimulus: run 65 537 output transfers.
  - Response: xfer_cnt = 16'h0001.
